task_answer_packetizer: RTL

- Parametrised result-packet buffer between a task core and the task manager; successor to the fixed 128-byte task output stage.
- Accumulates result words from the core into an internal packet buffer.
- Closes a packet when it is full or when the core signals last, then streams it to the manager with a valid/ready handshake, last flag and byte count.
- Adds variable-length packets, an optional pad-to-full mode, write backpressure and a sent-packet counter.

---
 rtl/task_answer_packetizer.sv | 113 +++++++++++
 1 files changed

// File: rtl/task_answer_packetizer.sv
// Result-packet buffer: collects core result words, closes a packet on full or last,
// then streams it to the task manager with valid/ready, last flag and byte count.
module task_answer_packetizer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MAX_WORDS   = 128,
    parameter int                    SIZE_WIDTH  = 12,
    parameter int                    PAD_TO_FULL = 0,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_input_last,
    output logic                  o_in_ready,
    input  logic                  i_tmanager_ready,
    output logic                  o_tanswer_ready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tanswer_data_last,
    output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
    output logic                  o_busy,
    output logic                  o_full,
    output logic [CNT_WIDTH-1:0]  o_packet_count
);
    localparam int AW  = $clog2(MAX_WORDS);
    localparam int PW  = AW + 1;
    localparam int BPW = DATA_WIDTH / 8;

    typedef enum logic {S_LOAD, S_SEND} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [MAX_WORDS];
    logic [PW-1:0]         count, rd_ptr, len;
    logic [PW-1:0]         count_nxt, close_len;
    logic [SIZE_WIDTH-1:0] size;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic                  wr_en, close, xfer, last_xfer;

    assign o_full                 = (count == PW'(MAX_WORDS));
    assign o_busy                 = (state == S_SEND);
    assign o_packet_size_in_bytes = size;
    assign o_packet_count         = pkt_cnt;
    assign close_len              = (PAD_TO_FULL != 0) ? PW'(MAX_WORDS) : count_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt           = state;
        o_in_ready          = 1'b0;
        o_tanswer_ready     = 1'b0;
        o_tdata             = '0;
        o_tanswer_data_last = 1'b0;
        wr_en               = 1'b0;
        close               = 1'b0;
        count_nxt           = count;
        xfer                = 1'b0;
        last_xfer           = 1'b0;
        case (state)
            S_LOAD: begin
                o_in_ready = !o_full;
                wr_en      = i_data_valid && o_in_ready;
                count_nxt  = count + PW'(wr_en);
                // a last with nothing buffered never produces an empty packet
                close      = (count_nxt == PW'(MAX_WORDS)) ||
                             (i_input_last && (count_nxt != '0));
                if (close) state_nxt = S_SEND;
            end
            S_SEND: begin
                o_tanswer_ready     = 1'b1;
                // words past the real payload read as padding
                o_tdata             = (rd_ptr < count) ? mem[rd_ptr[AW-1:0]] : PAD_VALUE;
                o_tanswer_data_last = (rd_ptr == len - PW'(1));
                xfer                = i_tmanager_ready;
                last_xfer           = xfer && o_tanswer_data_last;
                if (last_xfer) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[count[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count   <= '0;
            rd_ptr  <= '0;
            len     <= '0;
            size    <= '0;
            pkt_cnt <= '0;
        end else if (state == S_LOAD) begin
            count <= count_nxt;
            if (close) begin
                len  <= close_len;
                size <= SIZE_WIDTH'(close_len) * SIZE_WIDTH'(BPW);
            end
        end else if (xfer) begin
            if (last_xfer) begin
                count   <= '0;
                rd_ptr  <= '0;
                size    <= '0;
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end else begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end
endmodule
